// File: rtl/la_capture_pkg.sv
// Shared encodings for the logic analyzer capture controller: FSM states,
// trigger modes and register word offsets.
package la_capture_pkg;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } state_t;

    // Encoding 3 is left undecoded so it falls back to single-shot behaviour.
    typedef enum logic [1:0] {
        SINGLE_SHOT = 2'd0,
        INCREMENTAL = 2'd1,
        IMMEDIATE   = 2'd2
    } trigger_mode_t;

    localparam logic [2:0] REG_STATE         = 3'd0;
    localparam logic [2:0] REG_TRIGGER_MODE  = 3'd1;
    localparam logic [2:0] REG_TRIGGER_LOC   = 3'd2;
    localparam logic [2:0] REG_REQUEST_START = 3'd3;
    localparam logic [2:0] REG_REQUEST_STOP  = 3'd4;
    localparam logic [2:0] REG_READ_POINTER  = 3'd5;
    localparam logic [2:0] REG_WRITE_POINTER = 3'd6;
    localparam logic [2:0] REG_CAPTURE_COUNT = 3'd7;

endpackage

// File: rtl/la_capture_regs.sv
// Register-bus slice of the capture controller: decode, 1-cycle passthrough,
// trigger configuration registers and start/stop request pulses.
module la_capture_regs
    import la_capture_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'd0,
    parameter int unsigned AW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   addr_i,
    input  logic [15:0]   wdata_i,
    input  logic [15:0]   rdata_i,
    input  logic          rw_i,
    input  logic          valid_i,
    output logic [15:0]   addr_o,
    output logic [15:0]   wdata_o,
    output logic [15:0]   rdata_o,
    output logic          rw_o,
    output logic          valid_o,
    input  state_t        state,
    input  logic [AW-1:0] read_pointer,
    input  logic [AW-1:0] write_pointer,
    input  logic [15:0]   capture_count,
    output logic [1:0]    trigger_mode,
    output logic [AW-1:0] trigger_loc,
    output logic          start,
    output logic          stop
);

    logic [15:0] offset;
    logic        in_range;
    logic        wr;
    logic        rd;
    logic        cfg_open;
    logic [15:0] rd_word;

    // Unsigned wrap makes addresses below BASE_ADDR fall out of range too.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = offset < 16'd8;
    assign wr       = valid_i && rw_i && in_range;
    assign rd       = valid_i && !rw_i && in_range;
    assign cfg_open = (state == IDLE) || (state == CAPTURED);
    assign start    = wr && (offset[2:0] == REG_REQUEST_START) && wdata_i[0];
    assign stop     = wr && (offset[2:0] == REG_REQUEST_STOP) && wdata_i[0];

    always_comb begin
        rd_word = '0;
        case (offset[2:0])
            REG_STATE:         rd_word = 16'(state);
            REG_TRIGGER_MODE:  rd_word = 16'(trigger_mode);
            REG_TRIGGER_LOC:   rd_word = 16'(trigger_loc);
            REG_READ_POINTER:  rd_word = 16'(read_pointer);
            REG_WRITE_POINTER: rd_word = 16'(write_pointer);
            REG_CAPTURE_COUNT: rd_word = capture_count;
            default:           rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_o       <= '0;
            wdata_o      <= '0;
            rdata_o      <= '0;
            rw_o         <= 1'b0;
            valid_o      <= 1'b0;
            trigger_mode <= SINGLE_SHOT;
            trigger_loc  <= '0;
        end else begin
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            rdata_o <= rd ? rd_word : rdata_i;
            rw_o    <= rw_i;
            valid_o <= valid_i;
            if (wr && cfg_open && offset[2:0] == REG_TRIGGER_MODE)
                trigger_mode <= wdata_i[1:0];
            if (wr && cfg_open && offset[2:0] == REG_TRIGGER_LOC)
                trigger_loc <= wdata_i[AW-1:0];
        end
    end

endmodule

// File: rtl/la_capture_fsm.sv
// Logic analyzer capture controller: drives sample-memory write strobe and
// circular pointer. Define LA_CAPTURE_FSM_TRIG_COUNT_EN for the +7 capture counter.
module la_capture_fsm
    import la_capture_pkg::*;
#(
    parameter logic [15:0]  BASE_ADDR    = 16'd0,
    parameter int unsigned  SAMPLE_DEPTH = 1024,
    localparam int unsigned AW           = $clog2(SAMPLE_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig,
    input  logic [15:0]   addr_i,
    input  logic [15:0]   wdata_i,
    input  logic [15:0]   rdata_i,
    input  logic          rw_i,
    input  logic          valid_i,
    output logic [15:0]   addr_o,
    output logic [15:0]   wdata_o,
    output logic [15:0]   rdata_o,
    output logic          rw_o,
    output logic          valid_o,
    output logic          write_enable_o,
    output logic [AW-1:0] write_pointer_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state;
    state_t        state_next;
    logic          we;
    logic          we_next;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [1:0]    trigger_mode;
    logic [AW-1:0] trigger_loc;
    logic          start;
    logic          stop;
    logic          start_ok;
    logic          incr;
    logic          immediate;
    logic          last_write;
    logic [15:0]   capture_count;

    la_capture_regs #(
        .BASE_ADDR (BASE_ADDR),
        .AW        (AW)
    ) u_regs (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_i       (rdata_i),
        .rw_i          (rw_i),
        .valid_i       (valid_i),
        .addr_o        (addr_o),
        .wdata_o       (wdata_o),
        .rdata_o       (rdata_o),
        .rw_o          (rw_o),
        .valid_o       (valid_o),
        .state         (state),
        .read_pointer  (rp),
        .write_pointer (wp),
        .capture_count (capture_count),
        .trigger_mode  (trigger_mode),
        .trigger_loc   (trigger_loc),
        .start         (start),
        .stop          (stop)
    );

    assign incr       = trigger_mode == INCREMENTAL;
    assign immediate  = trigger_mode == IMMEDIATE;
    assign start_ok   = start && ((state == IDLE) || (state == CAPTURED));
    assign last_write = we && ((wp + PTR_ONE) == rp);

    always_comb begin
        state_next = state;
        we_next    = 1'b0;
        case (state)
            IDLE, CAPTURED: begin
                if (start_ok) begin
                    if (incr || immediate) begin
                        state_next = CAPTURING;
                        we_next    = !incr;
                    end else begin
                        state_next = (trigger_loc == '0) ? IN_POSITION : MOVE_TO_POSITION;
                        we_next    = 1'b1;
                    end
                end
            end
            // wp restarts at 0 on start, so it doubles as the pre-trigger count.
            MOVE_TO_POSITION: begin
                we_next = 1'b1;
                if (wp == trigger_loc - PTR_ONE)
                    state_next = IN_POSITION;
            end
            IN_POSITION: begin
                we_next = 1'b1;
                if (trig) begin
                    if ((wp + PTR_ONE) == rp) begin
                        state_next = CAPTURED;
                        we_next    = 1'b0;
                    end else begin
                        state_next = CAPTURING;
                    end
                end
            end
            CAPTURING: begin
                if (last_write)
                    state_next = CAPTURED;
                else
                    we_next = incr ? trig : 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (stop) begin
            state_next = IDLE;
            we_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            we    <= 1'b0;
        end else begin
            state <= state_next;
            we    <= we_next;
        end
    end

    // The trigger-cycle sample is not pre-trigger history, so rp holds on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (start_ok && !stop) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (we)
                wp <= wp + PTR_ONE;
            if (state == IN_POSITION && !trig)
                rp <= rp + PTR_ONE;
        end
    end

`ifdef LA_CAPTURE_FSM_TRIG_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            capture_count <= '0;
        else if (state_next == CAPTURED && state != CAPTURED)
            capture_count <= capture_count + 16'd1;
    end
`else
    assign capture_count = '0;
`endif

    assign write_enable_o  = we;
    assign write_pointer_o = wp;

endmodule
